bin_to_bcd_seq: RTL and testbench

- Iterative (shift-add-3, "double dabble") binary-to-BCD converter.
- Sits directly upstream of the 3-channel display data plexer: its packed BCD result drives the plexer's 12-bit data input as {hundreds, tens, ones} = {dig2, dig1, dig0}.
- Takes one binary sample per start request and produces DIGITS packed BCD digits after BIN_WIDTH clock cycles.
- Holds the last result stable between conversions so the display never shows intermediate values.

---
 rtl/bin_to_bcd_seq.sv | 104 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 (double dabble) binary-to-BCD converter.
// One iteration per clock; the packed result is held stable between conversions.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CW-1:0] LAST_ITER = CW'(BIN_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [0:0]           state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [SW-1:0]        scratch_q, scratch_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SW-1:0]        bcd_q, bcd_d;

  logic [SW-1:0]           adj;
  logic [SW+BIN_WIDTH-1:0] shifted;

  // Every digit is corrected in parallel before the joint shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                              (scratch_q[4*gi +: 4] + 4'd3) :
                              scratch_q[4*gi +: 4];
    end
  endgenerate

  assign shifted = {adj, bin_q} << 1;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, bin_d} = shifted;
        cnt_d              = cnt_q + CNT_ONE;
        if (cnt_q == LAST_ITER) begin
          // Only the finished value ever reaches the output register.
          bcd_d   = shifted[SW+BIN_WIDTH-1:BIN_WIDTH];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized checks of bin_to_bcd_seq against a decimal-arithmetic
// reference, including a behavioural 3-channel digit plexer on its output.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  int          errors = 0;
  int          checks = 0;
  logic [11:0] exp_bcd;
  logic [1:0]  sel_q;

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display plexer select: free-running 0-1-2 counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= 2'd0;
    else        sel_q <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
  end

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int ref_digit(input int v, input int idx);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    ref_digit = (v / p) % 10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One full conversion with cycle-exact latency checks. glitch_at >= 0 raises
  // start with a different bin_in at that busy cycle to show it is ignored.
  task automatic run_conv(input int v, input int glitch_at);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    bin_in = 8'(v);
    start  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == glitch_at) begin
        start  = 1'b1;
        bin_in = 8'd7;
      end else begin
        start  = 1'b0;
        bin_in = 8'($urandom);
      end
      chk("busy_hi", 32'(busy), 32'd1);
      chk("done_lo", 32'(done), 32'd0);
      chk("bcd_hold", 32'(bcd_out), 32'(exp_bcd));
    end
    start = 1'b0;
    @(negedge clk);
    exp_bcd = ref_bcd(v);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_lo", 32'(busy), 32'd0);
    chk("bcd_result", 32'(bcd_out), 32'(exp_bcd));
    $display("conv bin=%0d bcd=%03h expected=%03h", v, bcd_out, exp_bcd);
  endtask

  initial begin
    int vals[3];
    int v;
    logic [3:0] dig;

    rst_n   = 1'b0;
    start   = 1'b0;
    bin_in  = 8'd0;
    exp_bcd = 12'h000;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd_out), 32'd0);
    end

    run_conv(255, -1);
    run_conv(199, -1);
    run_conv(0, -1);

    // Start raised mid-conversion must not queue a second one.
    run_conv(42, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_requeue_busy", 32'(busy), 32'd0);
      chk("no_requeue_done", 32'(done), 32'd0);
      chk("no_requeue_bcd", 32'(bcd_out), 32'h042);
    end

    // Continuous start: a result every 9 cycles.
    vals[0] = 10; vals[1] = 99; vals[2] = 100;
    @(negedge clk);
    bin_in = 8'(vals[0]);
    start  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done_lo", 32'(done), 32'd0);
      if (j < 2) bin_in = 8'(vals[j+1]);
      else       start  = 1'b0;
      repeat (7) @(negedge clk);
      chk("b2b_pre_done", 32'(done), 32'd0);
      @(negedge clk);
      exp_bcd = ref_bcd(vals[j]);
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_bcd", 32'(bcd_out), 32'(exp_bcd));
      $display("b2b bin=%0d bcd=%03h expected=%03h", vals[j], bcd_out, exp_bcd);
    end

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bin_in = 8'd128;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    exp_bcd = 12'h000;
    @(negedge clk);
    chk("abort_hold_bcd", 32'(bcd_out), 32'd0);
    rst_n = 1'b1;
    run_conv(128, -1);

    for (int r = 0; r < 20; r++) begin
      v = int'($urandom_range(255, 0));
      run_conv(v, -1);
    end

    // Exhaustive sweep, observing each digit through the display plexer.
    for (int n = 0; n < 256; n++) begin
      run_conv(n, -1);
      for (int c = 0; c < 3; c++) begin
        dig = bcd_out[4*sel_q +: 4];
        chk("plex_digit", 32'(dig), 32'(ref_digit(n, int'(sel_q))));
        chk("plex_range", 32'(dig <= 4'd9), 32'd1);
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
